// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Publishes BCD digits, a leading-zero mask and a saturating overflow flag.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_lz,
  output logic                  o_ovf,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0]     CNT_INIT = CW'(BIN_W);
  localparam logic [DW-1:0]     NINES    = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] LZ_RST   = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [BIN_W-1:0]  bin_q;
  logic [DW-1:0]     dig_q;
  logic [DW-1:0]     dig_adj;
  logic [DW-1:0]     pub_bcd;
  logic [DIGITS-1:0] pub_lz;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic              all_zero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CW'(1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Add-3 correction per digit; a corrected digit is at most 12, so no nibble carry.
  always_comb begin
    dig_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] >= 4'd5) begin
        dig_adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
      end else begin
        dig_adj[4*k +: 4] = dig_q[4*k +: 4];
      end
    end
  end

  // Mask is derived from the value actually published, so saturation clears it.
  always_comb begin
    pub_bcd  = ovf_q ? NINES : dig_q;
    pub_lz   = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero  = all_zero && (pub_bcd[4*k +: 4] == 4'd0);
      pub_lz[k] = all_zero;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q  <= '0;
      dig_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      o_bcd  <= '0;
      o_lz   <= LZ_RST;
      o_ovf  <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= (state_q == S_FIN);
      o_busy <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            bin_q <= i_bin;
            dig_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= CNT_INIT;
          end
        end
        S_SHIFT: begin
          {dig_q, bin_q} <= {dig_adj[DW-2:0], bin_q, 1'b0};
          ovf_q          <= ovf_q | dig_adj[DW-1];
          cnt_q          <= cnt_q - CW'(1);
        end
        S_FIN: begin
          o_bcd <= pub_bcd;
          o_lz  <= pub_lz;
          o_ovf <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq at DIGITS=5 and DIGITS=4
module tb_bin2bcd_seq;

  localparam int unsigned LAT = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin;

  logic [19:0] bcd5;
  logic [4:0]  lz5;
  logic        ovf5, busy5, done5;
  logic [15:0] bcd4;
  logic [3:0]  lz4;
  logic        ovf4, busy4, done4;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bin(bin),
    .o_bcd(bcd5), .o_lz(lz5), .o_ovf(ovf5), .o_busy(busy5), .o_done(done5)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bin(bin),
    .o_bcd(bcd4), .o_lz(lz4), .o_ovf(ovf4), .o_busy(busy4), .o_done(done4)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] bcd;
    logic [9:0]  lz;
    logic        ovf;
    int unsigned at;
  } exp_t;

  exp_t q5[$];
  exp_t q4[$];
  int checks = 0;
  int failures = 0;
  int seen5 = 0, seen4 = 0;
  int pushed5 = 0, pushed4 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [39:0] b, input logic [9:0] l, input logic o);
    exp_t e;
    e.bcd = b; e.lz = l; e.ovf = o; e.at = 0;
    return e;
  endfunction

  function automatic exp_t model(input int unsigned v, input int d);
    exp_t e;
    longint lim = 1;
    int unsigned n = v;
    logic allz = 1'b1;
    e.bcd = '0; e.lz = '0; e.ovf = 1'b0; e.at = 0;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (longint'(v) > lim - 1) begin
      e.ovf = 1'b1;
      for (int i = 0; i < d; i++) e.bcd[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < d; i++) begin
        e.bcd[4*i +: 4] = 4'(n % 10);
        n = n / 10;
      end
    end
    for (int k = d - 1; k >= 1; k--) begin
      allz = allz && (e.bcd[4*k +: 4] == 4'd0);
      e.lz[k] = allz;
    end
    return e;
  endfunction

  // Called at the negedge where start is driven; the accepting edge is the next one.
  task automatic push_exp(input exp_t e5, input exp_t e4);
    exp_t a, b;
    a = e5; b = e4;
    a.at = cyc + 1; b.at = cyc + 1;
    q5.push_back(a); q4.push_back(b);
    pushed5++; pushed4++;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q5.size() == 0 && q4.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", q5.size() + q4.size(), 0);
    pushed5 -= q5.size(); pushed4 -= q4.size();
    q5.delete(); q4.delete();
  endtask

  task automatic convert(input logic [15:0] v, input exp_t e5, input exp_t e4);
    @(negedge clk);
    start = 1'b1; bin = v;
    push_exp(e5, e4);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done5) begin
      if (q5.size() == 0) begin
        check("unexpected_done5", 1, 0);
      end else begin
        e = q5.pop_front();
        seen5++;
        check("bcd5", bcd5, e.bcd);
        check("lz5", lz5, e.lz);
        check("ovf5", ovf5, e.ovf);
        check("latency5", cyc - e.at, LAT);
        check("busy_done5", busy5, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", 1, 0);
      end else begin
        e = q4.pop_front();
        seen4++;
        check("bcd4", bcd4, e.bcd);
        check("lz4", lz4, e.lz);
        check("ovf4", ovf4, e.ovf);
        check("latency4", cyc - e.at, LAT);
        check("busy_done4", busy4, 0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(negedge clk);
    check("rst_bcd5", bcd5, 20'h00000);
    check("rst_lz5", lz5, 5'b11110);
    check("rst_busy5", busy5, 0);
    check("rst_done5", done5, 0);
    check("rst_ovf5", ovf5, 0);
    check("rst_lz4", lz4, 4'b1110);
    rst = 1'b0;

    convert(16'd1234,  mk(40'h01234, 10'b10000, 0), mk(40'h1234, 10'b0000, 0));
    convert(16'd65535, mk(40'h65535, 10'b00000, 0), mk(40'h9999, 10'b0000, 1));
    convert(16'd0,     mk(40'h00000, 10'b11110, 0), mk(40'h0000, 10'b1110, 0));
    convert(16'd12345, mk(40'h12345, 10'b00000, 0), mk(40'h9999, 10'b0000, 1));
    convert(16'd9999,  mk(40'h09999, 10'b10000, 0), mk(40'h9999, 10'b0000, 0));

    // Starts and input changes during a conversion must be ignored.
    @(negedge clk);
    start = 1'b1; bin = 16'd42;
    push_exp(mk(40'h00042, 10'b11100, 0), mk(40'h0042, 10'b1100, 0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; bin = 16'd999;
    check("busy_mid", busy5, 1);
    @(negedge clk);
    start = 1'b0; bin = 16'd0;
    repeat (6) @(negedge clk);
    start = 1'b1; bin = 16'd12345;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done5) break;
      @(negedge clk);
    end
    check("wait_done42", done5, 1);
    if (done5) begin
      start = 1'b1; bin = 16'd7;
      push_exp(mk(40'h00007, 10'b11110, 0), mk(40'h0007, 10'b1110, 0));
      @(negedge clk);
      start = 1'b0;
    end
    drain();

    // Asynchronous reset mid-conversion abandons it without a done pulse.
    @(negedge clk);
    start = 1'b1; bin = 16'd500;
    push_exp(mk(40'h00500, 10'b11000, 0), mk(40'h0500, 10'b1000, 0));
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bcd5", bcd5, 20'h00000);
    check("arst_lz5", lz5, 5'b11110);
    check("arst_ovf5", ovf5, 0);
    check("arst_busy5", busy5, 0);
    check("arst_done5", done5, 0);
    check("arst_bcd4", bcd4, 16'h0000);
    check("arst_lz4", lz4, 4'b1110);
    pushed5 -= q5.size(); pushed4 -= q4.size();
    q5.delete(); q4.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    convert(16'd500, mk(40'h00500, 10'b11000, 0), mk(40'h0500, 10'b1000, 0));

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      convert(v, model(v, 5), model(v, 4));
    end

    repeat (3) @(negedge clk);
    check("done_count5", seen5, pushed5);
    check("done_count4", seen4, pushed4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock. Sits directly upstream of the per-digit 7-segment decoders. It takes an unsigned binary value, for example a register or PC value tapped for debug, and produces one 4-bit BCD nibble per display digit. It also produces a leading-zero mask so the display stage can blank unused digits. A start/busy/done handshake lets a slow display refresh request conversions without stalling the core.

## Interface
- BIN_W, 16, width of binary input; legal range 4..32.
- DIGITS, 5, number of BCD output digits; legal range 1..10.
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  conversion request; sampled only in IDLE.
- i_bin  in  BIN_W  unsigned value; captured on the accepted-start edge only.
- o_bcd  out  4*DIGITS  result; digit k occupies bits [4k+3:4k], with k=0 the least significant; holds the last result until the next done.
- o_lz  out  DIGITS  bit k=1 means digit k is a leading zero; bit 0 is always 0.
- o_ovf  out  1  result exceeded 10^DIGITS-1; valid with o_bcd.
- o_busy  out  1  conversion in progress (state SHIFT or FIN).
- o_done  out  1  one-cycle pulse; o_bcd, o_lz and o_ovf are updated in the same cycle.

## Operation
- Reset is asynchronous, independent of the clock, and overrides everything. It applies:
  - state=IDLE, o_bcd=0, o_lz={DIGITS-1 ones, 0}, o_ovf=0, o_busy=0, o_done=0.
  - The working shift register, digit register and counter are cleared.
  - A conversion in progress is abandoned and produces no done pulse.
- States:
  - IDLE: wait for start.
  - SHIFT: perform one iteration per cycle for BIN_W cycles.
  - FIN: publish the result, then return to IDLE.
- IDLE -> SHIFT on i_start=1. Load the binary shift register with i_bin, clear the working digits and the sticky overflow bit, and set counter=BIN_W.
- In each SHIFT cycle:
  - Every working digit >=5 gets +3 (4-bit add, no carry between digits).
  - The {digits, binary} register then shifts left by 1.
  - The bit leaving the top digit ORs into the sticky overflow bit.
  - The counter decrements. SHIFT -> FIN when the counter reaches 1 before decrement, i.e. after exactly BIN_W shifts.
- In FIN, register the outputs:
  - If overflow=0: o_bcd=working digits, o_ovf=0.
  - If overflow=1: o_bcd saturates to all digits 9, o_ovf=1.
  - o_lz[k]=1 iff digits k..DIGITS-1 of the published o_bcd are all zero, for k>=1; o_lz[0]=0.
  - o_done=1 for one cycle; FIN -> IDLE.
- i_start is ignored while o_busy=1. There is no queueing, and i_bin changes during a conversion have no effect.
- i_start=1 in the cycle o_done=1 is accepted, since the state is IDLE.
- Working digit arithmetic is 4 bits wide with wrap-free correction: after the add-3 step a digit never exceeds 12, so no nibble overflow occurs.

## Timing
- Start sampled at edge 0: o_busy=1 after edge 0.
- Shifts occur on edges 1..BIN_W.
- Edge BIN_W+1 (FIN): outputs update, o_done=1, o_busy=0.
- Edge BIN_W+2: o_done=0.
- Latency from start edge to done-visible is BIN_W+1 edges, which is 17 at default parameters.
- Back-to-back throughput is one conversion per BIN_W+2 cycles.
- o_busy and o_done are never both 1.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Defaults: reset, then check o_bcd=0x00000, o_lz=5'b11110, o_busy=0, o_done=0. Start with i_bin=1234, then require:
  - o_done high exactly 17 cycles after the start edge,
  - o_bcd=0x01234, o_lz=5'b10000, o_ovf=0.
- Defaults, i_bin=65535 -> o_bcd=0x65535, o_lz=5'b00000, o_ovf=0. Then i_bin=0 -> o_bcd=0x00000, o_lz=5'b11110.
- DIGITS=4, i_bin=12345 -> o_ovf=1, o_bcd=0x9999, o_lz=4'b0000. Then i_bin=9999 -> o_ovf=0, o_bcd=0x9999.
- Start with 42, then:
  - toggle i_bin and pulse i_start on cycles 3 and 10 of the conversion: exactly one done, with o_bcd=0x00042;
  - start with 7 in the done cycle: accepted, with a second done 17 cycles later and o_bcd=0x00007.
- Start with 500 and assert i_rst asynchronously (mid-cycle) after 8 shifts. Require:
  - all outputs are at their reset values immediately, with no done pulse;
  - a fresh start with 500 after reset release gives o_bcd=0x00500.
- Randomised regression: 1000 random 16-bit values vs a reference model, covering the o_bcd, o_lz and o_ovf checks, o_done=1 exactly BIN_W+1 edges after each accepted start, and o_busy/o_done mutual exclusion.
